// File: rtl/aha_ahb_to_axi_bridge.sv
// rtl/aha_ahb_to_axi_bridge.sv - single-outstanding AHB-Lite 32-bit slave to AXI4 64-bit master bridge
module aha_ahb_to_axi_bridge #(
    parameter logic [3:0] AXI_ID = 4'h0
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    // AHB-Lite slave
    input  logic        HSEL,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic [31:0] HADDR,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    // AXI4 write address
    output logic [3:0]  M_AXI_AWID,
    output logic [31:0] M_AXI_AWADDR,
    output logic [7:0]  M_AXI_AWLEN,
    output logic [2:0]  M_AXI_AWSIZE,
    output logic [1:0]  M_AXI_AWBURST,
    output logic        M_AXI_AWLOCK,
    output logic [3:0]  M_AXI_AWCACHE,
    output logic [2:0]  M_AXI_AWPROT,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    // AXI4 write data
    output logic [63:0] M_AXI_WDATA,
    output logic [7:0]  M_AXI_WSTRB,
    output logic        M_AXI_WLAST,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,
    // AXI4 write response
    input  logic [3:0]  M_AXI_BID,
    input  logic [1:0]  M_AXI_BRESP,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,
    // AXI4 read address
    output logic [3:0]  M_AXI_ARID,
    output logic [31:0] M_AXI_ARADDR,
    output logic [7:0]  M_AXI_ARLEN,
    output logic [2:0]  M_AXI_ARSIZE,
    output logic [1:0]  M_AXI_ARBURST,
    output logic        M_AXI_ARLOCK,
    output logic [3:0]  M_AXI_ARCACHE,
    output logic [2:0]  M_AXI_ARPROT,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    // AXI4 read data
    input  logic [3:0]  M_AXI_RID,
    input  logic [63:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RLAST,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  size_q, size_d;
    logic [3:0]  hprot_q, hprot_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [31:0] hrdata_q, hrdata_d;

    logic        accept;
    logic [3:0]  axcache;
    logic [2:0]  axprot;
    logic [7:0]  wstrb;

    // Only bit 1 of HTRANS matters (NONSEQ/SEQ); burst type, IDs and LAST are not needed.
    logic unused_inputs;
    assign unused_inputs = ^{HTRANS[0], HBURST, M_AXI_BID, M_AXI_BRESP[0],
                             M_AXI_RID, M_AXI_RRESP[0], M_AXI_RLAST};

    assign accept = HSEL & HTRANS[1] & HREADY;

    // State and captured address-phase registers
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= ST_IDLE;
            addr_q    <= 32'h0;
            size_q    <= 3'h0;
            hprot_q   <= 4'h0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            hrdata_q  <= 32'h0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            hprot_q   <= hprot_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            hrdata_q  <= hrdata_d;
        end
    end

    // Next-state logic: one AXI transaction per accepted AHB transfer
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        hprot_d   = hprot_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        hrdata_d  = hrdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d  = HADDR;
                    size_d  = HSIZE;
                    hprot_d = HPROT;
                    state_d = HWRITE ? ST_WR_REQ : ST_RD_REQ;
                end
            end
            ST_WR_REQ: begin
                aw_done_d = aw_done_q | M_AXI_AWREADY;
                w_done_d  = w_done_q | M_AXI_WREADY;
                // Both channels done (possibly in the same cycle): clear flags for the next write.
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (M_AXI_BVALID) begin
                    state_d = M_AXI_BRESP[1] ? ST_ERR1 : ST_IDLE;
                end
            end
            ST_RD_REQ: begin
                if (M_AXI_ARREADY) begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (M_AXI_RVALID) begin
                    hrdata_d = addr_q[2] ? M_AXI_RDATA[63:32] : M_AXI_RDATA[31:0];
                    state_d  = M_AXI_RRESP[1] ? ST_ERR1 : ST_IDLE;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Byte-lane strobe on the 64-bit bus from captured size and low address bits
    always_comb begin
        wstrb = 8'h0F << {addr_q[2], 2'b00};
        case (size_q)
            3'd0:    wstrb = 8'h01 << addr_q[2:0];
            3'd1:    wstrb = 8'h03 << {addr_q[2:1], 1'b0};
            default: wstrb = 8'h0F << {addr_q[2], 2'b00};
        endcase
    end

    assign axcache = {2'b00, hprot_q[3], hprot_q[2]};
    assign axprot  = {~hprot_q[0], 1'b0, hprot_q[1]};

    assign HREADYOUT = (state_q == ST_IDLE) || (state_q == ST_ERR2);
    assign HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
    assign HRDATA    = hrdata_q;

    assign M_AXI_AWID    = AXI_ID;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWLEN   = 8'd0;
    assign M_AXI_AWSIZE  = size_q;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = axcache;
    assign M_AXI_AWPROT  = axprot;
    assign M_AXI_AWVALID = (state_q == ST_WR_REQ) && !aw_done_q;

    // HWDATA stays stable through the data phase because HREADYOUT is held low.
    assign M_AXI_WDATA  = {HWDATA, HWDATA};
    assign M_AXI_WSTRB  = wstrb;
    assign M_AXI_WLAST  = 1'b1;
    assign M_AXI_WVALID = (state_q == ST_WR_REQ) && !w_done_q;

    assign M_AXI_BREADY = (state_q == ST_WR_RESP);

    assign M_AXI_ARID    = AXI_ID;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARLEN   = 8'd0;
    assign M_AXI_ARSIZE  = size_q;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = axcache;
    assign M_AXI_ARPROT  = axprot;
    assign M_AXI_ARVALID = (state_q == ST_RD_REQ);

    assign M_AXI_RREADY = (state_q == ST_RD_DATA);

endmodule

// File: tb/tb_aha_ahb_to_axi_bridge.sv
// tb/tb_aha_ahb_to_axi_bridge.sv - self-checking bench for aha_ahb_to_axi_bridge
module tb_aha_ahb_to_axi_bridge;

    localparam logic [3:0] ID = 4'h5;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
    logic [1:0]  HTRANS;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [3:0]  M_AXI_AWID, M_AXI_AWCACHE, M_AXI_ARID, M_AXI_ARCACHE, M_AXI_BID, M_AXI_RID;
    logic [31:0] M_AXI_AWADDR, M_AXI_ARADDR;
    logic [7:0]  M_AXI_AWLEN, M_AXI_ARLEN, M_AXI_WSTRB;
    logic [2:0]  M_AXI_AWSIZE, M_AXI_AWPROT, M_AXI_ARSIZE, M_AXI_ARPROT;
    logic [1:0]  M_AXI_AWBURST, M_AXI_ARBURST, M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_AWLOCK, M_AXI_AWVALID, M_AXI_AWREADY;
    logic        M_AXI_ARLOCK, M_AXI_ARVALID, M_AXI_ARREADY;
    logic [63:0] M_AXI_WDATA, M_AXI_RDATA;
    logic        M_AXI_WLAST, M_AXI_WVALID, M_AXI_WREADY;
    logic        M_AXI_BVALID, M_AXI_BREADY;
    logic        M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  last_wstrb;
    logic [63:0] last_wdata;
    logic [31:0] last_awaddr;
    logic [2:0]  last_awsize;

    // Single slave on the bus: the bus-level ready is this slave's ready.
    assign HREADY = HREADYOUT;

    always #5 ACLK = ~ACLK;

    aha_ahb_to_axi_bridge #(.AXI_ID(ID)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .HSEL(HSEL), .HTRANS(HTRANS), .HWRITE(HWRITE), .HREADY(HREADY),
        .HADDR(HADDR), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
        .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWLOCK(M_AXI_AWLOCK),
        .M_AXI_AWCACHE(M_AXI_AWCACHE), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BID(M_AXI_BID), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
        .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
        .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARLOCK(M_AXI_ARLOCK),
        .M_AXI_ARCACHE(M_AXI_ARCACHE), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RID(M_AXI_RID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: byte lanes covered by an aligned access of 2**size bytes.
    function automatic logic [7:0] exp_strb(input logic [31:0] a, input logic [2:0] s);
        int nb, base;
        logic [7:0] m;
        nb   = 1 << s;
        base = ((a % 8) / nb) * nb;
        m    = 8'h00;
        for (int i = 0; i < 8; i++) if (i >= base && i < base + nb) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [31:0] a, input logic [63:0] d);
        return ((a % 8) >= 4) ? 32'(d >> 32) : 32'(d & 64'hFFFF_FFFF);
    endfunction

    // Modifiable <- HPROT cacheable, bufferable <- HPROT bufferable.
    function automatic logic [3:0] exp_cache(input logic [3:0] p);
        return {2'b00, p[3], p[2]};
    endfunction

    // Instruction when HPROT says opcode fetch, privileged from HPROT privileged.
    function automatic logic [2:0] exp_prot(input logic [3:0] p);
        return {(p[0] == 1'b0), 1'b0, p[1]};
    endfunction

    function automatic int mx(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One AHB transfer with an emulated AXI slave. d_a: AW/AR ready delay,
    // d_w: W ready delay, d_r: cycles from request handshake to B/R valid.
    // Entered and left at a point where HREADYOUT is high, so calls pipeline back to back.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [3:0] hprot, input logic [31:0] wdata, input logic [63:0] rdata,
                        input logic [1:0] resp, input int d_a, input int d_w, input int d_r);
        int   hs_a, hs_w, n_av, n_wv, n_rsp, comp, exp_comp;
        logic drop_rsp, done, prev_resp, err;
        err = resp[1];
        hs_a = 0; hs_w = 0; n_av = 0; n_wv = 0; n_rsp = 0; comp = 0;
        drop_rsp = 0; done = 0; prev_resp = 0;
        HSEL = 1; HTRANS = 2'b10; HWRITE = wr; HADDR = addr; HSIZE = size; HPROT = hprot;
        HBURST = 3'($urandom_range(0, 7));
        @(posedge ACLK);
        for (int c = 1; c <= 60 && !done; c++) begin
            @(negedge ACLK);
            if (c == 1) begin
                HSEL = 0; HTRANS = 2'b00; HADDR = 32'h0;
                if (wr) HWDATA = wdata;
            end
            if (drop_rsp) begin
                M_AXI_BVALID = 0; M_AXI_RVALID = 0; drop_rsp = 0;
            end
            #1;
            if (HREADYOUT) begin
                done = 1; comp = c;
            end else begin
                prev_resp = HRESP;
                if (wr) begin
                    if (M_AXI_AWVALID) begin
                        n_av++;
                        last_awaddr = M_AXI_AWADDR; last_awsize = M_AXI_AWSIZE;
                        chk("aw_payload", {M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE,
                            M_AXI_AWBURST, M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT},
                            {ID, addr, 8'd0, size, 2'b01, 1'b0, exp_cache(hprot), exp_prot(hprot)});
                    end
                    if (M_AXI_WVALID) begin
                        n_wv++;
                        last_wstrb = M_AXI_WSTRB; last_wdata = M_AXI_WDATA;
                        chk("w_strb", M_AXI_WSTRB, exp_strb(addr, size));
                        chk("w_data", M_AXI_WDATA, {wdata, wdata});
                        chk("w_last", M_AXI_WLAST, 1);
                    end
                    M_AXI_AWREADY = M_AXI_AWVALID && (c >= 1 + d_a);
                    if (M_AXI_AWREADY) hs_a = c;
                    M_AXI_WREADY = M_AXI_WVALID && (c >= 1 + d_w);
                    if (M_AXI_WREADY) hs_w = c;
                    if (!M_AXI_BVALID && n_rsp == 0 && hs_a > 0 && hs_w > 0 &&
                        c >= mx(hs_a, hs_w) + 1 + d_r) begin
                        M_AXI_BVALID = 1; M_AXI_BRESP = resp; M_AXI_BID = ID;
                    end
                    if (M_AXI_BVALID && M_AXI_BREADY) begin
                        n_rsp++; drop_rsp = 1;
                    end
                end else begin
                    if (M_AXI_ARVALID) begin
                        n_av++;
                        chk("ar_payload", {M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE,
                            M_AXI_ARBURST, M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT},
                            {ID, addr, 8'd0, size, 2'b01, 1'b0, exp_cache(hprot), exp_prot(hprot)});
                    end
                    M_AXI_ARREADY = M_AXI_ARVALID && (c >= 1 + d_a);
                    if (M_AXI_ARREADY) hs_a = c;
                    if (!M_AXI_RVALID && n_rsp == 0 && hs_a > 0 && c >= hs_a + 1 + d_r) begin
                        M_AXI_RVALID = 1; M_AXI_RDATA = rdata; M_AXI_RRESP = resp;
                        M_AXI_RLAST = 1; M_AXI_RID = ID;
                    end
                    if (M_AXI_RVALID && M_AXI_RREADY) begin
                        n_rsp++; drop_rsp = 1;
                    end
                end
            end
        end
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
        M_AXI_BVALID = 0; M_AXI_RVALID = 0;
        exp_comp = (wr ? 3 + mx(d_a, d_w) : 3 + d_a) + d_r + (err ? 1 : 0);
        chk("complete_cycle", comp, exp_comp);
        chk("hresp_at_ready", HRESP, err);
        chk("addr_valid_cycles", n_av, 1 + d_a);
        if (wr) chk("wvalid_cycles", n_wv, 1 + d_w);
        chk("resp_consumed", n_rsp, 1);
        chk("resp_ready_low", {M_AXI_BREADY, M_AXI_RREADY}, 0);
        if (!wr && !err) chk("hrdata", HRDATA, exp_rdata(addr, rdata));
        if (err) begin
            chk("err1_hresp", prev_resp, 1);
            // A transfer presented during the second error cycle must be ignored.
            HSEL = 1; HTRANS = 2'b10; HWRITE = 1'($urandom_range(0, 1)); HADDR = 32'h40;
            @(negedge ACLK);
            #1;
            chk("err2_no_accept", {HREADYOUT, HRESP, M_AXI_ARVALID, M_AXI_AWVALID}, 4'b1000);
            HSEL = 0; HTRANS = 2'b00;
        end
    endtask

    initial begin
        logic [2:0]  sz;
        logic [31:0] ad;

        ARESETn = 0;
        HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HADDR = 0; HSIZE = 0; HBURST = 0; HPROT = 0; HWDATA = 0;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
        M_AXI_BID = 0; M_AXI_BRESP = 0; M_AXI_BVALID = 0;
        M_AXI_RID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0; M_AXI_RLAST = 0; M_AXI_RVALID = 0;
        repeat (3) @(negedge ACLK);
        #1;
        chk("reset_ahb", {HREADYOUT, HRESP, HRDATA}, {1'b1, 1'b0, 32'h0});
        chk("reset_axi", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 0);
        @(negedge ACLK);
        ARESETn = 1;

        // IDLE and BUSY transfers complete with zero wait, OKAY
        for (int t = 0; t < 2; t++) begin
            @(negedge ACLK);
            HSEL = 1; HTRANS = 2'(t); HWRITE = 1'(t); HADDR = 32'h8;
            @(negedge ACLK);
            #1;
            chk("idle_busy_zero_wait", {HREADYOUT, HRESP, M_AXI_AWVALID, M_AXI_ARVALID}, 4'b1000);
        end
        HSEL = 0; HTRANS = 2'b00;

        // Word write, zero-wait slave
        xfer(1, 32'h4, 3'd2, 4'b0011, 32'hDEADBEEF, 64'h0, 2'b00, 0, 0, 0);
        chk("word_awaddr", last_awaddr, 32'h4);
        chk("word_awsize", last_awsize, 3'd2);
        chk("word_wstrb", last_wstrb, 8'hF0);
        chk("word_wdata_hi", last_wdata[63:32], 32'hDEADBEEF);

        // Byte and halfword writes
        xfer(1, 32'h3, 3'd0, 4'b0001, 32'h12345678, 64'h0, 2'b00, 0, 1, 1);
        chk("byte_wstrb", last_wstrb, 8'h08);
        xfer(1, 32'h6, 3'd1, 4'b1101, 32'hCAFEF00D, 64'h0, 2'b01, 1, 0, 0);
        chk("half_wstrb", last_wstrb, 8'hC0);

        // Read lane select with R response delayed
        xfer(0, 32'h0, 3'd2, 4'b0011, 32'h0, 64'h1111_2222_3333_4444, 2'b00, 0, 0, 3);
        chk("read_lo", HRDATA, 32'h3333_4444);
        xfer(0, 32'h4, 3'd2, 4'b0011, 32'h0, 64'h1111_2222_3333_4444, 2'b00, 2, 0, 2);
        chk("read_hi", HRDATA, 32'h1111_2222);

        // Error responses (SLVERR on write, DECERR on read)
        xfer(1, 32'h10, 3'd2, 4'b0011, 32'hA5A5A5A5, 64'h0, 2'b10, 0, 0, 0);
        xfer(0, 32'h18, 3'd2, 4'b0011, 32'h0, 64'h5555_6666_7777_8888, 2'b11, 0, 0, 0);

        // AW delayed 4 cycles, W immediate; then read followed by write back to back
        xfer(1, 32'h20, 3'd2, 4'b0010, 32'h0BADCAFE, 64'h0, 2'b00, 4, 0, 0);
        xfer(0, 32'h24, 3'd2, 4'b0010, 32'h0, 64'h0123_4567_89AB_CDEF, 2'b00, 1, 0, 0);
        xfer(1, 32'h28, 3'd1, 4'b0010, 32'h7E57_7E57, 64'h0, 2'b00, 0, 3, 1);

        // Randomized transfers against the reference model
        for (int i = 0; i < 40; i++) begin
            sz = 3'($urandom_range(0, 2));
            ad = 32'($urandom_range(0, 32767));
            ad = ad & ~((32'd1 << sz) - 32'd1);
            xfer(1'($urandom_range(0, 1)), ad, sz, 4'($urandom_range(0, 15)), $urandom,
                 {$urandom, $urandom}, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Reset in the middle of a read
        xfer(0, 32'h4, 3'd2, 4'b0011, 32'h0, 64'hFEED_BEEF_0000_1111, 2'b00, 0, 0, 0);
        HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = 32'h10; HSIZE = 3'd2;
        @(posedge ACLK);
        @(negedge ACLK);
        HSEL = 0; HTRANS = 2'b00;
        #1;
        M_AXI_ARREADY = M_AXI_ARVALID;
        @(negedge ACLK);
        M_AXI_ARREADY = 0;
        #1;
        chk("rst_pre_rready", {M_AXI_RREADY, HRDATA}, {1'b1, 32'hFEED_BEEF});
        #2;
        ARESETn = 0;
        #1;
        chk("rst_async_ahb", {HREADYOUT, HRESP, HRDATA}, {1'b1, 1'b0, 32'h0});
        chk("rst_async_axi", {M_AXI_RREADY, M_AXI_ARVALID, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 0);
        @(negedge ACLK);
        ARESETn = 1;
        @(negedge ACLK);
        HSEL = 1; HTRANS = 2'b00;
        @(negedge ACLK);
        #1;
        chk("post_rst_idle_okay", {HREADYOUT, HRESP, M_AXI_ARVALID}, 3'b100);
        HSEL = 0;
        xfer(0, 32'h30, 3'd2, 4'b0011, 32'h0, 64'h9999_AAAA_BBBB_CCCC, 2'b00, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
